alu_ctrl_issue: RTL and testbench

Registered ID→EX issue stage for the RV32I pipeline: decodes the ID-stage instruction into the 4-bit ALU control code, selects and registers both ALU operands, and presents them to the EX-stage ALU one cycle later. It is the producer end of the ALU interface. It carries the pipeline stall/flush handshake and flags illegal ALU-class encodings.

---
 rtl/alu_ctrl_issue_if.sv | 28 ++
 rtl/alu_ctrl_issue.sv | 176 +++++++++++++++++
 tb/tb_alu_ctrl_issue.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_issue_if.sv
// ID->EX issue bus: ID-stage inputs, pipeline control and the registered
// EX-stage ALU outputs. The issue stage is the master (producer) end.
interface alu_ctrl_issue_if;
    logic [31:0] InstrD;
    logic        ValidD;
    logic [31:0] PCD;
    logic [31:0] RegOut1D;
    logic [31:0] RegOut2D;
    logic        StallE;
    logic        FlushE;
    logic [3:0]  AluContrlE;
    logic [31:0] Operand1E;
    logic [31:0] Operand2E;
    logic [4:0]  RdE;
    logic        RegWriteE;
    logic        ValidE;
    logic        IllegalE;

    modport master (
        input  InstrD, ValidD, PCD, RegOut1D, RegOut2D, StallE, FlushE,
        output AluContrlE, Operand1E, Operand2E, RdE, RegWriteE, ValidE, IllegalE
    );

    modport slave (
        output InstrD, ValidD, PCD, RegOut1D, RegOut2D, StallE, FlushE,
        input  AluContrlE, Operand1E, Operand2E, RdE, RegWriteE, ValidE, IllegalE
    );
endinterface

// File: rtl/alu_ctrl_issue.sv
// RV32I ID->EX issue stage: decodes the ID instruction into a 4-bit ALU code,
// selects both ALU operands and registers everything for the EX-stage ALU.
// Illegal ALU-class encodings become bubbles that carry IllegalE = 1.
module alu_ctrl_issue (
    input  logic              clk,
    input  logic              rst,
    alu_ctrl_issue_if.master  bus
);

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } alu_code_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [6:0] F7_BASE  = 7'b0000000;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;

    alu_code_t   dec_code;
    alu_code_t   base_code;
    logic [31:0] dec_op1;
    logic [31:0] dec_op2;
    logic        dec_regwrite;
    logic        dec_illegal;

    assign opcode = bus.InstrD[6:0];
    assign funct3 = bus.InstrD[14:12];
    assign funct7 = bus.InstrD[31:25];
    assign rd     = bus.InstrD[11:7];
    assign imm_i  = {{20{bus.InstrD[31]}}, bus.InstrD[31:20]};
    assign imm_s  = {{20{bus.InstrD[31]}}, bus.InstrD[31:25], bus.InstrD[11:7]};
    assign imm_u  = {bus.InstrD[31:12], 12'b0};

    // funct3 -> ALU code for the base (funct7 = 0) R-type / I-ALU operations
    always_comb begin
        base_code = ALU_ADD;
        case (funct3)
            3'b000:  base_code = ALU_ADD;
            3'b001:  base_code = ALU_SLL;
            3'b010:  base_code = ALU_SLT;
            3'b011:  base_code = ALU_SLTU;
            3'b100:  base_code = ALU_XOR;
            3'b101:  base_code = ALU_SRL;
            3'b110:  base_code = ALU_OR;
            default: base_code = ALU_AND;
        endcase
    end

    // Opcode decode: ALU code, operand selection, write-back enable, legality
    always_comb begin
        dec_code     = ALU_ADD;
        dec_op1      = bus.RegOut1D;
        dec_op2      = bus.RegOut2D;
        dec_regwrite = 1'b1;
        dec_illegal  = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE) begin
                    dec_code = base_code;
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_code = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_code = ALU_SRA;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_I: begin
                dec_op2  = imm_i;
                dec_code = base_code;
                if (funct3 == 3'b001 && funct7 != F7_BASE) begin
                    dec_illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT) begin
                        dec_code = ALU_SRA;
                    end else if (funct7 != F7_BASE) begin
                        dec_illegal = 1'b1;
                    end
                end
            end
            OP_LUI: begin
                dec_code = ALU_LUI;
                dec_op1  = 32'd0;
                dec_op2  = imm_u;
            end
            OP_AUIPC: begin
                dec_op1 = bus.PCD;
                dec_op2 = imm_u;
            end
            OP_LOAD: begin
                dec_op2 = imm_i;
            end
            OP_STORE: begin
                dec_op2      = imm_s;
                dec_regwrite = 1'b0;
            end
            OP_JAL, OP_JALR: begin
                dec_op1 = bus.PCD;
                dec_op2 = 32'd4;
            end
            OP_BR: begin
                dec_code     = ALU_SUB;
                dec_regwrite = 1'b0;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // EX-stage register: reset/flush load a bubble, stall holds, otherwise capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.AluContrlE <= ALU_ADD;
            bus.Operand1E  <= 32'd0;
            bus.Operand2E  <= 32'd0;
            bus.RdE        <= 5'd0;
            bus.RegWriteE  <= 1'b0;
            bus.ValidE     <= 1'b0;
            bus.IllegalE   <= 1'b0;
        end else if (bus.FlushE) begin
            bus.AluContrlE <= ALU_ADD;
            bus.Operand1E  <= 32'd0;
            bus.Operand2E  <= 32'd0;
            bus.RdE        <= 5'd0;
            bus.RegWriteE  <= 1'b0;
            bus.ValidE     <= 1'b0;
            bus.IllegalE   <= 1'b0;
        end else if (!bus.StallE) begin
            if (!bus.ValidD || dec_illegal) begin
                bus.AluContrlE <= ALU_ADD;
                bus.Operand1E  <= 32'd0;
                bus.Operand2E  <= 32'd0;
                bus.RdE        <= 5'd0;
                bus.RegWriteE  <= 1'b0;
                bus.ValidE     <= 1'b0;
                bus.IllegalE   <= bus.ValidD && dec_illegal;
            end else begin
                bus.AluContrlE <= dec_code;
                bus.Operand1E  <= dec_op1;
                bus.Operand2E  <= dec_op2;
                bus.RdE        <= rd;
                bus.RegWriteE  <= dec_regwrite && (rd != 5'd0);
                bus.ValidE     <= 1'b1;
                bus.IllegalE   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Testbench for alu_ctrl_issue: directed scenarios with literal expectations,
// then randomized traffic against a behavioural model of the issue stage.
module tb_alu_ctrl_issue;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_ctrl_issue_if bus();

    alu_ctrl_issue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0]  code;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        rw;
        logic        valid;
        logic        ill;
    } ex_t;

    ex_t exp_q;

    logic [3:0] rcode [0:7] = '{4'd3, 4'd0, 4'd8, 4'd9, 4'd5, 4'd1, 4'd6, 4'd7};
    logic [6:0] opcs  [0:8] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h63};

    function automatic ex_t mk(input logic [3:0] code, input logic [31:0] op1,
                               input logic [31:0] op2, input logic [4:0] rd,
                               input logic rw, input logic valid, input logic ill);
        ex_t e;
        e = '{code, op1, op2, rd, rw, valid, ill};
        return e;
    endfunction

    function automatic ex_t bubble();
        return mk(4'd3, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic ex_t obs();
        return mk(bus.AluContrlE, bus.Operand1E, bus.Operand2E, bus.RdE,
                  bus.RegWriteE, bus.ValidE, bus.IllegalE);
    endfunction

    // Behavioural decode of one ID instruction into what the EX slot should hold
    function automatic ex_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rdv;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_u;
        logic [3:0]  code;
        logic [31:0] a;
        logic [31:0] b;
        logic        rw;
        logic        legal;
        opc   = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        rdv   = ins[11:7];
        imm_i = {{20{ins[31]}}, ins[31:20]};
        imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        imm_u = {ins[31:12], 12'h000};
        code  = 4'd3;
        a     = r1;
        b     = r2;
        rw    = 1'b1;
        legal = 1'b1;
        case (opc)
            7'h33: begin
                if (f7 == 7'h00)                    code = rcode[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) code = 4'd4;
                else if (f7 == 7'h20 && f3 == 3'd5) code = 4'd2;
                else                                legal = 1'b0;
            end
            7'h13: begin
                b    = imm_i;
                code = rcode[f3];
                if (f3 == 3'd1 && f7 != 7'h00) legal = 1'b0;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20)      code = 4'd2;
                    else if (f7 != 7'h00) legal = 1'b0;
                end
            end
            7'h37: begin code = 4'd10; a = 32'd0; b = imm_u; end
            7'h17: begin a = pc; b = imm_u; end
            7'h03: begin b = imm_i; end
            7'h23: begin b = imm_s; rw = 1'b0; end
            7'h6F, 7'h67: begin a = pc; b = 32'd4; end
            7'h63: begin code = 4'd4; rw = 1'b0; end
            default: legal = 1'b0;
        endcase
        if (!legal) return mk(4'd3, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        return mk(code, a, b, rdv, rw && (rdv != 5'd0), 1'b1, 1'b0);
    endfunction

    // Next EX contents from the current state and the inputs presented to the edge
    function automatic ex_t ref_next(input ex_t prev);
        if (bus.FlushE)  return bubble();
        if (bus.StallE)  return prev;
        if (!bus.ValidD) return bubble();
        return ref_decode(bus.InstrD, bus.PCD, bus.RegOut1D, bus.RegOut2D);
    endfunction

    task automatic applyStimulus(input logic [31:0] ins, input logic valid,
                                 input logic [31:0] pc, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic stall,
                                 input logic flush);
        bus.InstrD   = ins;
        bus.ValidD   = valid;
        bus.PCD      = pc;
        bus.RegOut1D = r1;
        bus.RegOut2D = r2;
        bus.StallE   = stall;
        bus.FlushE   = flush;
    endtask

    task automatic tick();
        exp_q = ref_next(exp_q);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(32'h002081B3, 1'b1, 32'h0, 32'd1, 32'd2, 1'b0, 1'b0);
        exp_q = bubble();
        #1;
        checks++;
        if (obs() !== bubble()) begin
            errors++;
            $display("[TB] FAIL reset_idle: got %h expected %h", obs(), bubble());
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (obs() !== mk(4'd3, 32'd1, 32'd2, 5'd3, 1'b1, 1'b1, 1'b0)) begin
            errors++;
            $display("[TB] FAIL first_capture: got %h expected %h", obs(),
                     mk(4'd3, 32'd1, 32'd2, 5'd3, 1'b1, 1'b1, 1'b0));
        end
        applyStimulus(32'h40B50533, 1'b1, 32'h0, 32'd11, 32'd22, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        exp_q = bubble();
        checks++;
        if (obs() !== bubble()) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected %h", obs(), bubble());
        end
        #1 rst = 1'b0;
        tick();
        checks++;
        if (obs() !== mk(4'd4, 32'd11, 32'd22, 5'd10, 1'b1, 1'b1, 1'b0)) begin
            errors++;
            $display("[TB] FAIL post_reset_capture: got %h expected %h", obs(),
                     mk(4'd4, 32'd11, 32'd22, 5'd10, 1'b1, 1'b1, 1'b0));
        end
        applyStimulus(32'h00500093, 1'b1, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        tick();
        #2 rst = 1'b1;
        #1;
        exp_q = bubble();
        checks++;
        if (obs() !== bubble()) begin
            errors++;
            $display("[TB] FAIL reset_mid_stall: got %h expected %h", obs(), bubble());
        end
        #1 rst = 1'b0;
        tick();
        checks++;
        if (obs() !== bubble()) begin
            errors++;
            $display("[TB] FAIL stall_after_reset: got %h expected %h", obs(), bubble());
        end
    endtask

    task automatic test_rtype();
        applyStimulus(32'h40B50533, 1'b1, 32'h0, 32'd7, 32'd9, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs() !== mk(4'd4, 32'd7, 32'd9, 5'd10, 1'b1, 1'b1, 1'b0)) begin
            errors++;
            $display("[TB] FAIL rtype_sub: got %h expected %h", obs(),
                     mk(4'd4, 32'd7, 32'd9, 5'd10, 1'b1, 1'b1, 1'b0));
        end
    endtask

    task automatic test_itype();
        applyStimulus(32'h40335293, 1'b1, 32'h0, 32'h80, 32'h55, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs() !== mk(4'd2, 32'h80, 32'h403, 5'd5, 1'b1, 1'b1, 1'b0)) begin
            errors++;
            $display("[TB] FAIL itype_srai: got %h expected %h", obs(),
                     mk(4'd2, 32'h80, 32'h403, 5'd5, 1'b1, 1'b1, 1'b0));
        end
        applyStimulus(32'h123450B7, 1'b1, 32'h40, 32'h77, 32'h66, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs() !== mk(4'd10, 32'd0, 32'h12345000, 5'd1, 1'b1, 1'b1, 1'b0)) begin
            errors++;
            $display("[TB] FAIL itype_lui: got %h expected %h", obs(),
                     mk(4'd10, 32'd0, 32'h12345000, 5'd1, 1'b1, 1'b1, 1'b0));
        end
    endtask

    task automatic test_stall_flush();
        applyStimulus(32'h00500093, 1'b1, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus($urandom, 1'b1, $urandom, $urandom, $urandom, 1'b1, 1'b0);
            tick();
            checks++;
            if (obs() !== mk(4'd3, 32'd0, 32'd5, 5'd1, 1'b1, 1'b1, 1'b0)) begin
                errors++;
                $display("[TB] FAIL stall_hold_%0d: got %h expected %h", i, obs(),
                         mk(4'd3, 32'd0, 32'd5, 5'd1, 1'b1, 1'b1, 1'b0));
            end
        end
        applyStimulus(32'h00500093, 1'b1, 32'h0, 32'd0, 32'd0, 1'b1, 1'b1);
        tick();
        checks++;
        if (obs() !== bubble()) begin
            errors++;
            $display("[TB] FAIL stall_and_flush: got %h expected %h", obs(), bubble());
        end
    endtask

    task automatic test_illegal();
        applyStimulus(32'h02B50533, 1'b1, 32'h0, 32'd3, 32'd4, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs() !== mk(4'd3, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1)) begin
            errors++;
            $display("[TB] FAIL illegal_flag: got %h expected %h", obs(),
                     mk(4'd3, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1));
        end
        applyStimulus(32'h002081B3, 1'b1, 32'h0, 32'd4, 32'd5, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs() !== mk(4'd3, 32'd4, 32'd5, 5'd3, 1'b1, 1'b1, 1'b0)) begin
            errors++;
            $display("[TB] FAIL illegal_cleared: got %h expected %h", obs(),
                     mk(4'd3, 32'd4, 32'd5, 5'd3, 1'b1, 1'b1, 1'b0));
        end
        applyStimulus(32'h02B50533, 1'b1, 32'h0, 32'd3, 32'd4, 1'b0, 1'b0);
        tick();
        applyStimulus(32'h002081B3, 1'b1, 32'h0, 32'd4, 32'd5, 1'b1, 1'b0);
        tick();
        checks++;
        if (obs() !== mk(4'd3, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1)) begin
            errors++;
            $display("[TB] FAIL illegal_stalled: got %h expected %h", obs(),
                     mk(4'd3, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1));
        end
        applyStimulus(32'h002081B3, 1'b1, 32'h0, 32'd4, 32'd5, 1'b0, 1'b1);
        tick();
        checks++;
        if (obs() !== bubble()) begin
            errors++;
            $display("[TB] FAIL illegal_flushed: got %h expected %h", obs(), bubble());
        end
    endtask

    task automatic test_misc();
        applyStimulus(32'h008000EF, 1'b1, 32'h100, 32'h9, 32'h8, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs() !== mk(4'd3, 32'h100, 32'd4, 5'd1, 1'b1, 1'b1, 1'b0)) begin
            errors++;
            $display("[TB] FAIL jal_link: got %h expected %h", obs(),
                     mk(4'd3, 32'h100, 32'd4, 5'd1, 1'b1, 1'b1, 1'b0));
        end
        applyStimulus(32'h00208033, 1'b1, 32'h0, 32'd1, 32'd2, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs() !== mk(4'd3, 32'd1, 32'd2, 5'd0, 1'b0, 1'b1, 1'b0)) begin
            errors++;
            $display("[TB] FAIL add_x0: got %h expected %h", obs(),
                     mk(4'd3, 32'd1, 32'd2, 5'd0, 1'b0, 1'b1, 1'b0));
        end
        applyStimulus(32'hFE20AE23, 1'b1, 32'h0, 32'h1000, 32'h5, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs() !== mk(4'd3, 32'h1000, 32'hFFFFFFFC, 5'd28, 1'b0, 1'b1, 1'b0)) begin
            errors++;
            $display("[TB] FAIL store_imm: got %h expected %h", obs(),
                     mk(4'd3, 32'h1000, 32'hFFFFFFFC, 5'd28, 1'b0, 1'b1, 1'b0));
        end
        applyStimulus(32'h02B50533, 1'b0, 32'h0, 32'd3, 32'd4, 1'b0, 1'b0);
        tick();
        checks++;
        if (obs() !== bubble()) begin
            errors++;
            $display("[TB] FAIL validd_low: got %h expected %h", obs(), bubble());
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc;
        logic [6:0] f7;
        logic [4:0] rdv;
        int         k;
        k   = $urandom_range(0, 9);
        opc = (k == 9) ? 7'($urandom) : opcs[k];
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1, 2:    f7 = 7'h20;
            default: f7 = 7'($urandom);
        endcase
        if (k < 2 && $urandom_range(0, 1) == 0) f7 = 7'h00;
        rdv = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        return {f7, 5'($urandom), 5'($urandom), 3'($urandom), rdv, opc};
    endfunction

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            applyStimulus(rand_instr(), ($urandom_range(0, 99) < 85), $urandom,
                          $urandom, $urandom, ($urandom_range(0, 99) < 20),
                          ($urandom_range(0, 99) < 10));
            tick();
            checks++;
            if (obs() !== exp_q) begin
                errors++;
                $display("[TB] FAIL random_%0d: got %h expected %h", i, obs(), exp_q);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_stall_flush();
        test_illegal();
        test_misc();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
